// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding fetch from imem, holds the
// fetched instruction until the core accepts it, then advances the PC.
//
// state  | meaning
// IDLE   | after reset, nothing requested
// REQ    | imem_req high at PC, waiting for grant
// WAIT   | granted, waiting for rvalid
// HOLD   | instruction held for the core until accept
module fetch_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             pc_sel,
  input  logic [WIDTH-1:0] alu_target,
  output logic             misalign_err,
  output logic [31:0]      instret
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_tgt;
  logic             accept;
  logic             resp;

  assign accept = inst_valid & inst_ready;
  // Responses only count while a fetch is outstanding.
  assign resp   = (state == S_WAIT) & imem_rvalid;
  assign pc_seq = pc + WIDTH'(4);
  assign pc_tgt = {alu_target[WIDTH-1:2], 2'b00};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (imem_gnt) state_nxt = S_WAIT;
      S_WAIT: if (imem_rvalid) state_nxt = S_HOLD;
      S_HOLD: if (accept) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= RESET_VEC;
      inst_valid   <= 1'b0;
      inst_out     <= '0;
      inst_pc      <= '0;
      misalign_err <= 1'b0;
      instret      <= '0;
    end else begin
      state        <= state_nxt;
      misalign_err <= 1'b0;
      if (resp) begin
        inst_out   <= imem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end
      if (accept) begin
        pc           <= pc_sel ? pc_tgt : pc_seq;
        inst_valid   <= 1'b0;
        instret      <= instret + 32'd1;
        misalign_err <= pc_sel & (|alu_target[1:0]);
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: scoreboard of expected (pc, instruction)
// pairs pushed when a response is driven and popped when inst_valid rises.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_gnt, imem_rvalid, inst_ready, pc_sel;
  logic [31:0] imem_rdata, alu_target;

  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst_out, inst_pc, instret;

  logic        imem_req2, inst_valid2, misalign_err2;
  logic [31:0] imem_addr2, inst_out2, inst_pc2, instret2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  fetch_ctrl #(.WIDTH(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .pc_sel(pc_sel), .alu_target(alu_target),
    .misalign_err(misalign_err), .instret(instret)
  );

  fetch_ctrl #(.WIDTH(32), .RESET_VEC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2),
    .inst_ready(inst_ready), .pc_sel(pc_sel), .alu_target(alu_target),
    .misalign_err(misalign_err2), .instret(instret2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ; ends in HOLD with the scoreboard entry checked.
  task automatic fetch(input logic [31:0] data, input int gnt_dly, input int rv_dly);
    sb_t e;
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      chk("req_stall_req", {31'd0, imem_req}, 32'd1);
      chk("req_stall_addr", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req_low", {31'd0, imem_req}, 32'd0);
    chk("misalign_clear", {31'd0, misalign_err}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      step();
      chk("wait_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    sb.push_back('{pc: exp_pc, data: data});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_out", inst_out, e.data);
    end
  endtask

  task automatic accept(input logic sel, input logic [31:0] tgt);
    logic exp_mis;
    inst_ready = 1'b1;
    pc_sel     = sel;
    alu_target = tgt;
    exp_mis    = sel && (tgt[1:0] != 2'b00);
    exp_pc     = sel ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    exp_ret    = exp_ret + 32'd1;
    step();
    inst_ready = 1'b0;
    pc_sel     = 1'b0;
    alu_target = 32'h0;
    chk("acc_addr", imem_addr, exp_pc);
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_valid_low", {31'd0, inst_valid}, 32'd0);
    chk("acc_instret", instret, exp_ret);
    chk("acc_misalign", {31'd0, misalign_err}, {31'd0, exp_mis});
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    pc_sel = 1'b0; imem_rdata = 32'h0; alu_target = 32'h0;
    exp_pc = 32'h0; exp_ret = 32'h0;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_addr_wrapvec", imem_addr2, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    step();
    chk("idle_to_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_addr_wrapvec", imem_addr2, 32'hFFFF_FFFC);

    fetch(32'h0000_0013, 0, 0);
    accept(1'b0, 32'h0000_0300);
    chk("pc_wrap", imem_addr2, 32'h0000_0000);

    fetch(32'h00A0_0093, 5, 0);
    accept(1'b1, 32'h0000_0100);

    fetch(32'h0010_0113, 0, 2);
    accept(1'b1, 32'h0000_0102);

    // HOLD stall: selectors and stray responses must not disturb anything.
    fetch(32'h0020_8193, 0, 0);
    for (int i = 0; i < 4; i++) begin
      pc_sel      = i[0];
      alu_target  = 32'h0000_1000 + 32'(i);
      imem_rvalid = (i == 2);
      step();
      imem_rvalid = 1'b0;
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst_out", inst_out, 32'h0020_8193);
      chk("stall_inst_pc", inst_pc, exp_pc);
      chk("stall_addr", imem_addr, exp_pc);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instret", instret, exp_ret);
    end
    accept(1'b0, 32'h0);

    // Reset while a fetch is outstanding, then a late response in IDLE.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("pre_rst_wait", {31'd0, imem_req}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_instret", instret, 32'h0);
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    chk("late_rvalid_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, imem_req}, 32'd1);
    step();
    imem_rvalid = 1'b0;
    chk("rvalid_in_req_valid", {31'd0, inst_valid}, 32'd0);
    chk("rvalid_in_req_addr", imem_addr, 32'h0);
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    fetch(32'h0000_0073, 0, 0);
    accept(1'b0, 32'h0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
